seg7_scroll_display: RTL and testbench

Parametrised N-digit multiplexed 7-segment display engine with an internal character FIFO, tail/scroll window selection and a blinking cursor digit. It sits between the TX/RX message logic and the board's shared segment lines and active-low digit enables. It replaces fixed 8-character packed-bus display wiring: producers push 5-bit character codes, and the block decides what is visible on each digit.

---
 rtl/seg7_scroll_display.sv | 171 +++++++++++++++++
 tb/tb_seg7_scroll_display.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scroll_display.sv
// seg7_scroll_display: N-digit multiplexed 7-segment engine with a
// character FIFO, tail/scroll window selection and a blinking cursor.
module seg7_scroll_display #(
   parameter int NUM_DIGITS = 8,
   parameter int BUF_DEPTH  = 16,
   parameter int SCAN_DIV   = 50000,
   parameter int SCROLL_DIV = 25000000,
   parameter int BLINK_DIV  = 12500000,
   parameter int LW         = $clog2(BUF_DEPTH + 1)
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iWrEn,
   input  logic [4:0]            iWrChar,
   input  logic                  iClear,
   input  logic                  iScrollEn,
   input  logic                  iCursorEn,
   input  logic [4:0]            iCursorChar,
   output logic [6:0]            oSEG,
   output logic [NUM_DIGITS-1:0] oDIGIT,
   output logic [LW-1:0]         oLen,
   output logic                  oFull
);

   localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int DW = $clog2(NUM_DIGITS);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [4:0]    chars [BUF_DEPTH];
   logic [LW-1:0] len;
   logic [LW-1:0] off;
   logic [SW-1:0] scan_cnt;
   logic [RW-1:0] scroll_cnt;
   logic [BW-1:0] blink_cnt;
   logic          blink_vis;
   logic [DW-1:0] scan_idx;
   logic          full;
   logic          wr_take;
   logic          scroll_act;
   logic [6:0]    seg_next;
   int            win_w;
   int            text_pos;
   int            pos;

   function automatic logic [6:0] glyph(input logic [4:0] code);
      case (code)
         5'd0:  glyph = 7'h7F;
         5'd1:  glyph = 7'h08;
         5'd2:  glyph = 7'h03;
         5'd3:  glyph = 7'h46;
         5'd4:  glyph = 7'h21;
         5'd5:  glyph = 7'h06;
         5'd6:  glyph = 7'h0E;
         5'd7:  glyph = 7'h42;
         5'd8:  glyph = 7'h09;
         5'd9:  glyph = 7'h79;
         5'd10: glyph = 7'h61;
         5'd11: glyph = 7'h0A;
         5'd12: glyph = 7'h47;
         5'd13: glyph = 7'h6A;
         5'd14: glyph = 7'h2B;
         5'd15: glyph = 7'h23;
         5'd16: glyph = 7'h0C;
         5'd17: glyph = 7'h18;
         5'd18: glyph = 7'h2F;
         5'd19: glyph = 7'h12;
         5'd20: glyph = 7'h07;
         5'd21: glyph = 7'h41;
         5'd22: glyph = 7'h63;
         5'd23: glyph = 7'h55;
         5'd24: glyph = 7'h1B;
         5'd25: glyph = 7'h11;
         5'd26: glyph = 7'h24;
         5'd27: glyph = 7'h3F;
         5'd28: glyph = 7'h77;
         5'd29: glyph = 7'h37;
         5'd30: glyph = 7'h2C;
         default: glyph = 7'h00;
      endcase
   endfunction

   assign full    = (len == LW'(BUF_DEPTH));
   assign wr_take = iWrEn & ~iClear;
   assign oLen    = len;
   assign oFull   = full;

   // Shift-on-overflow keeps index 0 as the oldest character.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         len <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) chars[i] <= '0;
      end else if (iClear) begin
         len <= '0;
      end else if (iWrEn) begin
         if (full) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) chars[i] <= chars[i+1];
            chars[BUF_DEPTH-1] <= iWrChar;
         end else begin
            chars[len[AW-1:0]] <= iWrChar;
            len <= len + LW'(1);
         end
      end
   end

   always_comb begin
      win_w      = iCursorEn ? NUM_DIGITS - 1 : NUM_DIGITS;
      scroll_act = iScrollEn && (int'(len) > win_w);
      text_pos   = int'(scan_idx) - (iCursorEn ? 1 : 0);
      pos        = scroll_act ? int'(off) + win_w - 1 - text_pos
                              : int'(len) - 1 - text_pos;
      seg_next   = 7'h7F;
      if (iCursorEn && scan_idx == '0) begin
         if (blink_vis) seg_next = glyph(iCursorChar);
      end else if (pos >= 0 && pos < int'(len)) begin
         seg_next = glyph(chars[pos[AW-1:0]]);
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         scroll_cnt <= '0;
         off        <= '0;
      end else if (iWrEn || iClear || !scroll_act) begin
         scroll_cnt <= '0;
         off        <= '0;
      end else if (scroll_cnt == RW'(SCROLL_DIV - 1)) begin
         scroll_cnt <= '0;
         off <= (int'(off) >= int'(len) - win_w) ? '0 : off + LW'(1);
      end else begin
         scroll_cnt <= scroll_cnt + RW'(1);
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         blink_cnt <= '0;
         blink_vis <= 1'b1;
      end else if (wr_take) begin
         blink_cnt <= '0;
         blink_vis <= 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink_vis <= ~blink_vis;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // Outputs load when the scan counter is at zero, so the very first
   // edge after reset lights the leftmost digit.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         scan_cnt <= '0;
         scan_idx <= DW'(NUM_DIGITS - 1);
         oDIGIT   <= '1;
         oSEG     <= 7'h7F;
      end else begin
         scan_cnt <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0
                                                     : scan_cnt + SW'(1);
         if (scan_cnt == '0) begin
            oDIGIT   <= ~(NUM_DIGITS'(1) << scan_idx);
            oSEG     <= seg_next;
            scan_idx <= (scan_idx == '0) ? DW'(NUM_DIGITS - 1)
                                         : scan_idx - DW'(1);
         end
      end
   end

endmodule

// File: tb/tb_seg7_scroll_display.sv
// Bench for seg7_scroll_display: directed and randomized stimulus
// checked against a queue-based model of the visible window.
module tb_seg7_scroll_display;

   localparam int N = 4;
   localparam int D = 6;
   localparam int SCAN = 4;
   localparam int SCROLL = 40;
   localparam int BLINK = 20;
   localparam int LW = $clog2(D + 1);
   localparam logic [6:0] GL [32] = '{
      7'h7F, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42,
      7'h09, 7'h79, 7'h61, 7'h0A, 7'h47, 7'h6A, 7'h2B, 7'h23,
      7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07, 7'h41, 7'h63, 7'h55,
      7'h1B, 7'h11, 7'h24, 7'h3F, 7'h77, 7'h37, 7'h2C, 7'h00};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wr = 1'b0, clr = 1'b0, scr = 1'b0, cur = 1'b0;
   logic [4:0] ch = '0, cch = '0;
   logic [6:0] seg;
   logic [N-1:0] dig;
   logic [LW-1:0] len;
   logic full;

   seg7_scroll_display #(
      .NUM_DIGITS(N), .BUF_DEPTH(D), .SCAN_DIV(SCAN),
      .SCROLL_DIV(SCROLL), .BLINK_DIV(BLINK)
   ) dut (
      .iCLK(clk), .iRST(rst), .iWrEn(wr), .iWrChar(ch),
      .iClear(clr), .iScrollEn(scr), .iCursorEn(cur),
      .iCursorChar(cch), .oSEG(seg), .oDIGIT(dig),
      .oLen(len), .oFull(full)
   );

   always #5 clk = ~clk;

   logic [4:0] q [$];
   int edges, last_wr, last_mod, scroll_start;
   logic [N-1:0] exp_dig;
   logic [6:0] exp_seg;
   logic seg_chk;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic model_reset();
      q.delete();
      edges = 0;
      last_wr = 0;
      last_mod = -10;
      scroll_start = 0;
      exp_dig = '1;
      exp_seg = 7'h7F;
      seg_chk = 1'b1;
   endtask

   // Advance one clock: predict what the next edge shows, then apply
   // the buffer and timer events of that edge to the model.
   task automatic tick();
      int e, w, n, off, base, d;
      logic vis, act;
      logic [4:0] win [$];
      e = edges + 1;
      w = cur ? N - 1 : N;
      n = q.size();
      act = scr && (n > w);
      off = act ? ((e - 1 - scroll_start) / SCROLL) % (n - w + 1) : 0;
      vis = (((e - 1 - last_wr) / BLINK) % 2) == 0;
      if ((e - 1) % SCAN == 0) begin
         d = N - 1 - ((e - 1) / SCAN) % N;
         win = {};
         if (n <= w) begin
            for (int i = 0; i < w - n; i++) win.push_back(5'd0);
            for (int i = 0; i < n; i++) win.push_back(q[i]);
         end else begin
            base = scr ? off : n - w;
            for (int i = 0; i < w; i++) win.push_back(q[base + i]);
         end
         exp_dig = '1;
         exp_dig[d] = 1'b0;
         if (cur && d == 0) exp_seg = vis ? GL[cch] : 7'h7F;
         else exp_seg = GL[win[N - 1 - d]];
         seg_chk = (e - last_mod) >= 2;
      end
      if (clr) begin
         q.delete();
         last_mod = e;
      end else if (wr) begin
         if (q.size() == D) void'(q.pop_front());
         q.push_back(ch);
         last_mod = e;
         last_wr = e;
      end
      if (clr || wr || !act) scroll_start = e;
      edges = e;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp += 4;
      if (dig !== '1) begin n_bad++; $display("FAIL rst_dig: got %b want 1111", dig); end
      if (seg !== 7'h7F) begin n_bad++; $display("FAIL rst_seg: got %h want 7f", seg); end
      if (len !== '0) begin n_bad++; $display("FAIL rst_len: got %0d want 0", len); end
      if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", full); end
      rst = 1'b0;
      tick();
      n_cmp++;
      if (dig !== 4'b0111) begin n_bad++; $display("FAIL first_dig: got %b want 0111", dig); end
      repeat (48) begin
         tick();
         n_cmp += 3;
         if (dig !== exp_dig) begin n_bad++; $display("FAIL scan_dig: got %b want %b edge %0d", dig, exp_dig, edges); end
         if (seg !== 7'h7F) begin n_bad++; $display("FAIL scan_seg: got %h want 7f edge %0d", seg, edges); end
         if (len !== '0) begin n_bad++; $display("FAIL scan_len: got %0d want 0", len); end
      end
   endtask

   task automatic test_right_align();
      cur = 1'b0; scr = 1'b0;
      ch = 5'd1; wr = 1'b1; tick();
      ch = 5'd2; tick();
      wr = 1'b0;
      repeat (40) begin
         tick();
         n_cmp += 2;
         if (dig !== exp_dig) begin n_bad++; $display("FAIL ra_dig: got %b want %b", dig, exp_dig); end
         if (len !== LW'(q.size())) begin n_bad++; $display("FAIL ra_len: got %0d want %0d", len, q.size()); end
         if (seg_chk) begin
            n_cmp++;
            if (seg !== exp_seg) begin n_bad++; $display("FAIL ra_seg: got %h want %h dig %b", seg, exp_seg, dig); end
         end
      end
   endtask

   task automatic test_full_overwrite();
      clr = 1'b1; tick(); clr = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         ch = 5'(c); wr = 1'b1; tick();
      end
      wr = 1'b0;
      n_cmp += 2;
      if (len !== LW'(6)) begin n_bad++; $display("FAIL fo_len: got %0d want 6", len); end
      if (full !== 1'b1) begin n_bad++; $display("FAIL fo_full: got %b want 1", full); end
      repeat (40) begin
         tick();
         n_cmp += 2;
         if (dig !== exp_dig) begin n_bad++; $display("FAIL fo_dig: got %b want %b", dig, exp_dig); end
         if (full !== (q.size() == D)) begin n_bad++; $display("FAIL fo_flag: got %b want %b", full, q.size() == D); end
         if (seg_chk) begin
            n_cmp++;
            if (seg !== exp_seg) begin n_bad++; $display("FAIL fo_seg: got %h want %h dig %b", seg, exp_seg, dig); end
         end
      end
   endtask

   task automatic test_scroll();
      scr = 1'b1; cur = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (k == 130) begin ch = 5'd9; wr = 1'b1; end
         tick();
         wr = 1'b0;
         n_cmp++;
         if (dig !== exp_dig) begin n_bad++; $display("FAIL sc_dig: got %b want %b", dig, exp_dig); end
         if (seg_chk) begin
            n_cmp++;
            if (seg !== exp_seg) begin n_bad++; $display("FAIL sc_seg: got %h want %h edge %0d", seg, exp_seg, edges); end
         end
      end
      scr = 1'b0;
   endtask

   task automatic test_cursor_blink();
      clr = 1'b1; tick(); clr = 1'b0;
      cur = 1'b1; cch = 5'd31;
      ch = 5'd1; wr = 1'b1; tick(); wr = 1'b0;
      repeat (160) begin
         tick();
         n_cmp++;
         if (dig !== exp_dig) begin n_bad++; $display("FAIL cb_dig: got %b want %b", dig, exp_dig); end
         if (seg_chk) begin
            n_cmp++;
            if (seg !== exp_seg) begin n_bad++; $display("FAIL cb_seg: got %h want %h edge %0d", seg, exp_seg, edges); end
         end
      end
      cur = 1'b0;
   endtask

   task automatic test_clear_priority();
      ch = 5'd3; wr = 1'b1; tick();
      clr = 1'b1; ch = 5'd5; tick();
      clr = 1'b0; wr = 1'b0;
      n_cmp += 2;
      if (len !== '0) begin n_bad++; $display("FAIL cp_len: got %0d want 0", len); end
      if (full !== 1'b0) begin n_bad++; $display("FAIL cp_full: got %b want 0", full); end
      repeat (20) begin
         tick();
         n_cmp++;
         if (len !== LW'(q.size())) begin n_bad++; $display("FAIL cp_hold: got %0d want %0d", len, q.size()); end
         if (seg_chk) begin
            n_cmp++;
            if (seg !== exp_seg) begin n_bad++; $display("FAIL cp_seg: got %h want %h", seg, exp_seg); end
         end
      end
   endtask

   task automatic test_random();
      repeat (1500) begin
         wr = ($urandom_range(0, 24) == 0);
         clr = ($urandom_range(0, 89) == 0);
         ch = 5'($urandom);
         if (wr && $urandom_range(0, 3) == 0) cur = ~cur;
         if (wr) cch = 5'($urandom);
         if ($urandom_range(0, 99) == 0) scr = ~scr;
         tick();
         n_cmp += 3;
         if (dig !== exp_dig) begin n_bad++; $display("FAIL rnd_dig: got %b want %b edge %0d", dig, exp_dig, edges); end
         if (len !== LW'(q.size())) begin n_bad++; $display("FAIL rnd_len: got %0d want %0d", len, q.size()); end
         if (full !== (q.size() == D)) begin n_bad++; $display("FAIL rnd_full: got %b want %b", full, q.size() == D); end
         if (seg_chk) begin
            n_cmp++;
            if (seg !== exp_seg) begin n_bad++; $display("FAIL rnd_seg: got %h want %h edge %0d", seg, exp_seg, edges); end
         end
      end
      wr = 1'b0; clr = 1'b0;
   endtask

   task automatic test_async_reset();
      scr = 1'b1;
      for (int c = 20; c < 26; c++) begin
         ch = 5'(c); wr = 1'b1; tick();
      end
      wr = 1'b0;
      repeat (9) tick();
      #2 rst = 1'b1;
      #1;
      n_cmp += 4;
      if (dig !== '1) begin n_bad++; $display("FAIL ar_dig: got %b want 1111", dig); end
      if (seg !== 7'h7F) begin n_bad++; $display("FAIL ar_seg: got %h want 7f", seg); end
      if (len !== '0) begin n_bad++; $display("FAIL ar_len: got %0d want 0", len); end
      if (full !== 1'b0) begin n_bad++; $display("FAIL ar_full: got %b want 0", full); end
      scr = 1'b0; cur = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (40) begin
         tick();
         n_cmp += 2;
         if (dig !== exp_dig) begin n_bad++; $display("FAIL ar_scan: got %b want %b", dig, exp_dig); end
         if (seg !== exp_seg) begin n_bad++; $display("FAIL ar_blank: got %h want %h", seg, exp_seg); end
      end
   endtask

   initial begin
      test_reset();
      test_right_align();
      test_full_overwrite();
      test_scroll();
      test_cursor_blink();
      test_clear_priority();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
